// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for the parallel-in serial-out transmitter.
// The master side drives words; the slave side is the transmitter.
interface piso_tx_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] data_in;
    logic             hold;
    logic             sdata;
    logic             sframe;
    logic             done;

    modport master (
        output load_valid,
        output data_in,
        output hold,
        input  load_ready,
        input  sdata,
        input  sframe,
        input  done
    );

    modport slave (
        input  load_valid,
        input  data_in,
        input  hold,
        output load_ready,
        output sdata,
        output sframe,
        output done
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word over valid/ready and shifts it out
// one bit per cycle with a frame strobe, an end-of-word pulse and a stall input.
module piso_tx #(
    parameter int unsigned WIDTH     = 8,    // must be >= 2
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic     clk,
    input logic     rst,
    piso_tx_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sdata_q, sdata_d;
    logic             sframe_q, sframe_d;

    logic             done;
    logic             load_ready;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shift_rest;

    // The shift register holds the bits still to be sent, so the next bit always sits at the
    // outgoing end and the bit currently on sdata lives only in sdata_q.
    always_comb begin
        if (MSB_FIRST) begin
            first_bit  = bus.data_in[WIDTH-1];
            load_rest  = bus.data_in << 1;
            next_bit   = shreg_q[WIDTH-1];
            shift_rest = shreg_q << 1;
        end else begin
            first_bit  = bus.data_in[0];
            load_rest  = bus.data_in >> 1;
            next_bit   = shreg_q[0];
            shift_rest = shreg_q >> 1;
        end
    end

    always_comb begin
        done       = (state_q == StShift) && (cnt_q == LastCnt) && !bus.hold;
        load_ready = (state_q == StIdle) || done;
        accept     = bus.load_valid && load_ready;

        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sdata_d  = sdata_q;
        sframe_d = sframe_q;

        if (accept) begin
            // Covers both a fresh start from idle and a gapless chain on the done cycle.
            state_d  = StShift;
            shreg_d  = load_rest;
            cnt_d    = '0;
            sdata_d  = first_bit;
            sframe_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sdata_d  = 1'b0;
                    sframe_d = 1'b0;
                end
                StShift: begin
                    if (!bus.hold) begin
                        if (cnt_q == LastCnt) begin
                            state_d  = StIdle;
                            shreg_d  = '0;
                            cnt_d    = '0;
                            sdata_d  = 1'b0;
                            sframe_d = 1'b0;
                        end else begin
                            shreg_d = shift_rest;
                            cnt_d   = cnt_q + 1'b1;
                            sdata_d = next_bit;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            cnt_q    <= '0;
            sdata_q  <= 1'b0;
            sframe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sdata_q  <= sdata_d;
            sframe_q <= sframe_d;
        end
    end

    assign bus.sdata      = sdata_q;
    assign bus.sframe     = sframe_q;
    assign bus.done       = done;
    assign bus.load_ready = load_ready;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an MSB-first and an LSB-first instance see identical stimulus
// and each is checked against hand-derived bit sequences.
module tb_piso_tx;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    piso_tx_if #(.WIDTH(8)) bus0 ();
    piso_tx_if #(.WIDTH(8)) bus1 ();

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic lv, input logic [7:0] din, input logic hd);
        bus0.load_valid = lv;
        bus0.data_in    = din;
        bus0.hold       = hd;
        bus1.load_valid = lv;
        bus1.data_in    = din;
        bus1.hold       = hd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle outputs, packed as {sframe, sdata, done, load_ready}.
    task automatic check_idle(input string tag);
        #1;
        check_eq({tag, "_msb"}, 32'({bus0.sframe, bus0.sdata, bus0.done, bus0.load_ready}),
                 32'(4'b0001));
        check_eq({tag, "_lsb"}, 32'({bus1.sframe, bus1.sdata, bus1.done, bus1.load_ready}),
                 32'(4'b0001));
    endtask

    task automatic start(input logic [7:0] word, input logic hd);
        drive(1'b1, word, hd);
        #1;
        check_eq("start_ready", 32'({bus0.load_ready, bus1.load_ready}), 32'(2'b11));
        step();
    endtask

    // Called in the cycle that carries bit 0. load_valid rises from bit lv_from (8 = never) with
    // next_word; hold is high for hold_len cycles while bit hold_at is on sdata.
    task automatic tx_frame(input logic [7:0] word, input int lv_from, input logic [7:0] next_word,
                            input int hold_at, input int hold_len);
        int   k;
        int   h;
        logic hh;
        logic last;
        k = 0;
        h = 0;
        while (k < 8) begin
            hh   = (k == hold_at) && (h < hold_len);
            last = (k == 7) && !hh;
            drive(k >= lv_from, (k >= lv_from) ? next_word : 8'h00, hh);
            #1;
            check_eq("bit_msb", 32'({bus0.sframe, bus0.sdata, bus0.done, bus0.load_ready}),
                     32'({1'b1, word[3'(7 - k)], last, last}));
            check_eq("bit_lsb", 32'({bus1.sframe, bus1.sdata, bus1.done, bus1.load_ready}),
                     32'({1'b1, word[3'(k)], last, last}));
            step();
            if (hh) h++;
            else k++;
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();
        rst = 1'b0;
        check_idle("reset");

        // Single word, then idle.
        start(8'hA5, 1'b0);
        tx_frame(8'hA5, 8, 8'h00, -1, 0);
        check_idle("after_a5");

        // Back-to-back words chained on the done cycle.
        start(8'hA5, 1'b0);
        tx_frame(8'hA5, 7, 8'h3C, -1, 0);
        tx_frame(8'h3C, 8, 8'h00, -1, 0);
        check_idle("after_chain");

        // 0x01 exercises bit order on both instances; hold in idle must not block the load.
        start(8'h01, 1'b1);
        tx_frame(8'h01, 8, 8'h00, -1, 0);
        check_idle("after_01");

        // Three-cycle stall while bit 2 is on the line.
        start(8'hF0, 1'b0);
        tx_frame(8'hF0, 8, 8'h00, 2, 3);
        check_idle("after_hold");

        // Early load_valid must wait for the done cycle.
        start(8'h96, 1'b0);
        tx_frame(8'h96, 2, 8'h5A, -1, 0);
        tx_frame(8'h5A, 8, 8'h00, -1, 0);
        check_idle("after_flow");

        // Reset after bit 3 of 0xFF, with a competing load_valid that must be dropped.
        start(8'hFF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("ff_bits", 32'({bus0.sframe, bus0.sdata, bus1.sframe, bus1.sdata}),
                     32'(4'b1111));
            step();
        end
        rst = 1'b1;
        drive(1'b1, 8'h55, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        check_idle("mid_reset");
        step();
        check_idle("mid_reset_stay");

        start(8'h81, 1'b0);
        tx_frame(8'h81, 8, 8'h00, -1, 0);
        check_idle("after_81");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
